// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if: writeback request, regfile write port and forwarding lookup bundle
interface regfile_write_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = 5
);
    localparam int CW = $clog2(DEPTH + 1);
    logic          mem_valid;
    logic [AW-1:0] mem_reg;
    logic [DW-1:0] mem_data;
    logic          mem_ready;
    logic          alu_valid;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          alu_ready;
    logic          drain_en;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] fwd_reg1;
    logic [AW-1:0] fwd_reg2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_data1;
    logic [DW-1:0] fwd_data2;
    logic [CW-1:0] count;
    modport master (
        output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
               drain_en, fwd_reg1, fwd_reg2,
        input  mem_ready, alu_ready, RegWrite, WriteRegister, WriteData,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
    );
    modport slave (
        input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
               drain_en, fwd_reg1, fwd_reg2,
        output mem_ready, alu_ready, RegWrite, WriteRegister, WriteData,
               fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count
    );
endinterface

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: FIFO of pending regfile writes with forwarding; RFWQ_COALESCE_EN merges same-register requests
module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 64,
    parameter int AW    = 5
) (
    input logic                 clk,
    input logic                 reset,
    regfile_write_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] reg_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q, slot;
    logic [CW-1:0] count_q;
    logic          we_q;
    logic [AW-1:0] wreg_q;
    logic [DW-1:0] wdata_q;
    logic          ready, accept, push, pop, merge, alloc;
    logic [AW-1:0] in_reg;
    logic [DW-1:0] in_data;

    assign ready         = count_q < CW'(DEPTH);
    assign bus.mem_ready = ready;
    assign bus.alu_ready = ready & ~bus.mem_valid;
    assign accept        = (bus.mem_valid & ready) | (bus.alu_valid & bus.alu_ready);
    assign in_reg        = bus.mem_valid ? bus.mem_reg : bus.alu_reg;
    assign in_data       = bus.mem_valid ? bus.mem_data : bus.alu_data;
    assign push          = accept && in_reg != AW'(31);
    assign pop           = bus.drain_en && count_q != '0;
`ifdef RFWQ_COALESCE_EN
    // the youngest entry is only being popped when it is also the head
    assign merge = push && count_q != '0 && reg_q[wr_ptr_q - PW'(1)] == in_reg
                   && !(pop && count_q == CW'(1));
`else
    assign merge = 1'b0;
`endif
    assign alloc = push & ~merge;
    assign slot  = wr_ptr_q - PW'(merge);

    assign bus.count         = count_q;
    assign bus.RegWrite      = we_q;
    assign bus.WriteRegister = wreg_q;
    assign bus.WriteData     = wdata_q;

    // youngest match wins: scan FIFO oldest to newest over the output stage
    function automatic logic [DW:0] lookup(input logic [AW-1:0] r);
        logic [DW:0] res;
        res = (we_q && wreg_q == r) ? {1'b1, wdata_q} : '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < count_q && reg_q[rd_ptr_q + PW'(i)] == r)
                res = {1'b1, data_q[rd_ptr_q + PW'(i)]};
        return (r == AW'(31)) ? '0 : res;
    endfunction

    // forwarding lookups see only state already registered
    always_comb begin
        {bus.fwd_hit1, bus.fwd_data1} = lookup(bus.fwd_reg1);
        {bus.fwd_hit2, bus.fwd_data2} = lookup(bus.fwd_reg2);
    end

    // entry storage; a merge rewrites the youngest slot in place
    always_ff @(posedge clk) begin
        if (alloc || merge) begin
            reg_q[slot]  <= in_reg;
            data_q[slot] <= in_data;
        end
    end

    // pointers, occupancy and the registered regfile write stage
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
        end else begin
            we_q    <= pop;
            count_q <= count_q + CW'(alloc) - CW'(pop);
            if (alloc)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop) begin
                wreg_q   <= reg_q[rd_ptr_q];
                wdata_q  <= data_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed stimulus, queue-based reference model checked every cycle
module tb_regfile_write_queue;
    typedef struct packed {
        logic [4:0]  r;
        logic [63:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   passed = 0;
    ent_t q[$];
    logic        m_we = 1'b0;
    logic [4:0]  m_wreg = '0;
    logic [63:0] m_wdata = '0;
    bit          armed = 1'b0;

    regfile_write_queue_if #(.DEPTH(4), .DW(64), .AW(5)) bus ();

    regfile_write_queue #(.DEPTH(4), .DW(64), .AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [64:0] mfwd(input logic [4:0] r);
        if (r == 5'd31) return '0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].r == r) return {1'b1, q[i].d};
        if (m_we && m_wreg == r) return {1'b1, m_wdata};
        return '0;
    endfunction

    // reference model: compare at negedge, then advance to the state after the next posedge
    initial begin
        logic [64:0] e1, e2;
        logic [4:0]  pr;
        logic [63:0] pd;
        bit          rdy, acc, pop, push, mrg;
        ent_t        e;
        forever begin
            @(negedge clk);
            if (armed) begin
                e1 = mfwd(bus.fwd_reg1);
                e2 = mfwd(bus.fwd_reg2);
                chk("m_count", 64'(bus.count), 64'(q.size()));
                chk("m_mem_ready", 64'(bus.mem_ready), 64'(q.size() < 4));
                chk("m_alu_ready", 64'(bus.alu_ready), 64'(q.size() < 4 && !bus.mem_valid));
                chk("m_RegWrite", 64'(bus.RegWrite), 64'(m_we));
                chk("m_WriteRegister", 64'(bus.WriteRegister), 64'(m_wreg));
                chk("m_WriteData", bus.WriteData, m_wdata);
                chk("m_hit1", 64'(bus.fwd_hit1), 64'(e1[64]));
                chk("m_data1", bus.fwd_data1, e1[63:0]);
                chk("m_hit2", 64'(bus.fwd_hit2), 64'(e2[64]));
                chk("m_data2", bus.fwd_data2, e2[63:0]);
            end
            if (reset) begin
                q.delete();
                m_we = 1'b0;
                m_wreg = '0;
                m_wdata = '0;
                armed = 1'b1;
            end else begin
                rdy  = q.size() < 4;
                acc  = rdy && (bus.mem_valid || bus.alu_valid);
                pr   = bus.mem_valid ? bus.mem_reg : bus.alu_reg;
                pd   = bus.mem_valid ? bus.mem_data : bus.alu_data;
                pop  = bus.drain_en && q.size() > 0;
                push = acc && pr != 5'd31;
                mrg  = 1'b0;
`ifdef RFWQ_COALESCE_EN
                mrg = push && q.size() > 0 && q[q.size()-1].r == pr && !(pop && q.size() == 1);
`endif
                if (mrg) begin
                    e = q[q.size()-1];
                    e.d = pd;
                    q[q.size()-1] = e;
                end
                if (pop) begin
                    m_we = 1'b1;
                    m_wreg = q[0].r;
                    m_wdata = q[0].d;
                    void'(q.pop_front());
                end else m_we = 1'b0;
                if (push && !mrg) q.push_back('{r: pr, d: pd});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] r, input logic [63:0] d);
        bus.alu_valid = 1'b1;
        bus.alu_reg = r;
        bus.alu_data = d;
    endtask

    task automatic mem(input logic [4:0] r, input logic [63:0] d);
        bus.mem_valid = 1'b1;
        bus.mem_reg = r;
        bus.mem_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.mem_valid = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
        bus.alu_valid = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
        bus.drain_en = 1'b1; bus.fwd_reg1 = '0; bus.fwd_reg2 = '0;
        tick(); tick();
        reset = 1'b0;
        alu(5'd5, 64'h11);
        @(negedge clk);
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
        chk("rst_WriteRegister", 64'(bus.WriteRegister), 64'd0);
        chk("rst_WriteData", bus.WriteData, 64'd0);
        chk("t1_alu_ready", 64'(bus.alu_ready), 64'd1);
        tick(); bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("t1_count_q", 64'(bus.count), 64'd1);
        chk("t1_rw_early", 64'(bus.RegWrite), 64'd0);
        tick();
        @(negedge clk);
        chk("t1_rw", 64'(bus.RegWrite), 64'd1);
        chk("t1_wr", 64'(bus.WriteRegister), 64'd5);
        chk("t1_wd", bus.WriteData, 64'h11);
        chk("t1_count_e", 64'(bus.count), 64'd0);
        tick();
        mem(5'd3, 64'hA); alu(5'd4, 64'hB);
        @(negedge clk);
        chk("t2_mem_ready", 64'(bus.mem_ready), 64'd1);
        chk("t2_alu_ready", 64'(bus.alu_ready), 64'd0);
        tick(); bus.mem_valid = 1'b0;
        @(negedge clk);
        chk("t2_alu_ready2", 64'(bus.alu_ready), 64'd1);
        tick(); bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("t2_wr3", 64'(bus.WriteRegister), 64'd3);
        chk("t2_wd3", bus.WriteData, 64'hA);
        tick();
        @(negedge clk);
        chk("t2_wr4", 64'(bus.WriteRegister), 64'd4);
        chk("t2_wd4", bus.WriteData, 64'hB);
        tick();
        bus.drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            alu(5'(i), 64'h100 + 64'(i));
            tick();
        end
        alu(5'd6, 64'h66);
        @(negedge clk);
        chk("t3_count_full", 64'(bus.count), 64'd4);
        chk("t3_mem_ready", 64'(bus.mem_ready), 64'd0);
        chk("t3_alu_ready", 64'(bus.alu_ready), 64'd0);
        tick(); bus.alu_valid = 1'b0; bus.drain_en = 1'b1;
        @(negedge clk);
        chk("t3_x6_held", 64'(bus.count), 64'd4);
        for (int i = 1; i <= 4; i++) begin
            tick();
            @(negedge clk);
            chk("t3_rw", 64'(bus.RegWrite), 64'd1);
            chk("t3_order", 64'(bus.WriteRegister), 64'(i));
            chk("t3_data", bus.WriteData, 64'h100 + 64'(i));
        end
        tick();
        bus.drain_en = 1'b0;
        alu(5'd7, 64'd1);
        tick(); alu(5'd7, 64'd2);
        tick(); bus.alu_valid = 1'b0; bus.fwd_reg1 = 5'd7; bus.fwd_reg2 = 5'd31;
        @(negedge clk);
        chk("t4_hit1", 64'(bus.fwd_hit1), 64'd1);
        chk("t4_data1", bus.fwd_data1, 64'd2);
        chk("t4_hit2", 64'(bus.fwd_hit2), 64'd0);
        chk("t4_data2", bus.fwd_data2, 64'd0);
`ifdef RFWQ_COALESCE_EN
        chk("t4_count", 64'(bus.count), 64'd1);
`else
        chk("t4_count", 64'(bus.count), 64'd2);
`endif
        tick(); bus.drain_en = 1'b1;
        tick();
        @(negedge clk);
        chk("t4_out_hit", 64'(bus.fwd_hit1), 64'd1);
        chk("t4_out_data", bus.fwd_data1, 64'd2);
        tick(); tick();
        @(negedge clk);
        chk("t4_drained", 64'(bus.count), 64'd0);
        tick();
        alu(5'd31, 64'hFF);
        @(negedge clk);
        chk("t5_alu_ready", 64'(bus.alu_ready), 64'd1);
        tick(); bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("t5_count", 64'(bus.count), 64'd0);
        tick();
        @(negedge clk);
        chk("t5_rw", 64'(bus.RegWrite), 64'd0);
        tick();
        bus.drain_en = 1'b0;
        alu(5'd8, 64'h8);
        tick(); alu(5'd9, 64'h9);
        tick(); alu(5'd10, 64'hA0);
        tick(); bus.alu_valid = 1'b0;
        @(negedge clk);
        chk("t6_count3", 64'(bus.count), 64'd3);
        tick(); reset = 1'b1; bus.drain_en = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk);
        chk("t6_count0", 64'(bus.count), 64'd0);
        chk("t6_rw0", 64'(bus.RegWrite), 64'd0);
        tick(); tick();
        @(negedge clk);
        chk("t6_rw_later", 64'(bus.RegWrite), 64'd0);
        tick();
        for (int i = 0; i < 32; i++) begin
            bus.mem_valid = (i % 3 == 0);
            bus.mem_reg = 5'(i % 8);
            bus.mem_data = 64'h1000 + 64'(i);
            bus.alu_valid = (i % 2 == 0);
            bus.alu_reg = (i % 5 == 4) ? 5'd31 : 5'(i % 6);
            bus.alu_data = 64'h2000 + 64'(i);
            bus.drain_en = (i % 4 != 3) && (i % 9 != 8);
            bus.fwd_reg1 = 5'(i % 8);
            bus.fwd_reg2 = 5'((i + 3) % 6);
            tick();
        end
        bus.mem_valid = 1'b0; bus.alu_valid = 1'b0; bus.drain_en = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk);
        chk("t7_empty", 64'(bus.count), 64'd0);
        tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
